// File: rtl/wb_stage.sv
// Writeback stage: registers the MEM result, extracts/extends load data and flags misaligned loads.
// Optional retired-instruction counter on retire_cnt when WB_RETIRE_CNT_EN is defined.
module wb_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_wreg,
    input  logic [4:0]  mem_wd,
    input  logic [31:0] mem_wdata,
    input  logic        mem_ld,
    input  logic [2:0]  mem_ldtype,
    input  logic [31:0] mem_rdata,
    input  logic        stall,
    input  logic        flush,
    output logic        wb_we,
    output logic [4:0]  wb_waddr,
    output logic [31:0] wb_wdata,
    output logic        wb_valid,
    output logic        wb_adel
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [31:0] retire_cnt
`endif
);

    localparam logic [2:0] LdLb  = 3'b001;
    localparam logic [2:0] LdLbu = 3'b010;
    localparam logic [2:0] LdLh  = 3'b011;
    localparam logic [2:0] LdLhu = 3'b100;

    logic [1:0]  addr_lo;
    logic        is_half;
    logic        is_word;
    logic        misaligned;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_data;

    logic        valid_q, valid_d;
    logic        we_q, we_d;
    logic [4:0]  waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        adel_q, adel_d;

    // Reserved load types fall into the word class.
    always_comb begin
        addr_lo    = mem_wdata[1:0];
        is_half    = (mem_ldtype == LdLh) || (mem_ldtype == LdLhu);
        is_word    = !is_half && (mem_ldtype != LdLb) && (mem_ldtype != LdLbu);
        misaligned = mem_valid & mem_ld &
                     ((is_half & addr_lo[0]) | (is_word & (addr_lo != 2'b00)));

        unique case (addr_lo)
            2'd0:    lane_b = mem_rdata[31:24];
            2'd1:    lane_b = mem_rdata[23:16];
            2'd2:    lane_b = mem_rdata[15:8];
            default: lane_b = mem_rdata[7:0];
        endcase
        lane_h = addr_lo[1] ? mem_rdata[15:0] : mem_rdata[31:16];

        case (mem_ldtype)
            LdLb:    load_data = {{24{lane_b[7]}}, lane_b};
            LdLbu:   load_data = {24'h0, lane_b};
            LdLh:    load_data = {{16{lane_h[15]}}, lane_h};
            LdLhu:   load_data = {16'h0, lane_h};
            default: load_data = mem_rdata;
        endcase
    end

    // Flush beats stall beats capture; adel is a one-cycle pulse on every path.
    always_comb begin
        valid_d = valid_q;
        we_d    = we_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        adel_d  = 1'b0;
        if (flush) begin
            valid_d = 1'b0;
            we_d    = 1'b0;
        end else if (!stall) begin
            valid_d = mem_valid;
            we_d    = mem_valid & mem_wreg & (mem_wd != 5'd0) & ~misaligned;
            waddr_d = mem_wd;
            wdata_d = mem_ld ? load_data : mem_wdata;
            adel_d  = misaligned;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= 5'd0;
            wdata_q <= 32'd0;
            adel_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            adel_q  <= adel_d;
        end
    end

    assign wb_valid = valid_q;
    assign wb_we    = we_q;
    assign wb_waddr = waddr_q;
    assign wb_wdata = wdata_q;
    assign wb_adel  = adel_q;

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_q, retire_d;

    always_comb begin
        retire_d = retire_q;
        if (!flush && !stall && mem_valid && !misaligned) begin
            retire_d = retire_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            retire_q <= 32'd0;
        end else begin
            retire_q <= retire_d;
        end
    end

    assign retire_cnt = retire_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: reference model feeds a scoreboard queue, popped at each output.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, mem_wreg, mem_ld, stall, flush;
    logic [4:0]  mem_wd;
    logic [31:0] mem_wdata, mem_rdata;
    logic [2:0]  mem_ldtype;
    logic        wb_we, wb_valid, wb_adel;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
`endif

    always #5 clk = ~clk;

    wb_stage dut (
        .clk        (clk),
        .rst        (rst),
        .mem_valid  (mem_valid),
        .mem_wreg   (mem_wreg),
        .mem_wd     (mem_wd),
        .mem_wdata  (mem_wdata),
        .mem_ld     (mem_ld),
        .mem_ldtype (mem_ldtype),
        .mem_rdata  (mem_rdata),
        .stall      (stall),
        .flush      (flush),
        .wb_we      (wb_we),
        .wb_waddr   (wb_waddr),
        .wb_wdata   (wb_wdata),
        .wb_valid   (wb_valid),
        .wb_adel    (wb_adel)
`ifdef WB_RETIRE_CNT_EN
        ,
        .retire_cnt (retire_cnt)
`endif
    );

    typedef struct {
        logic        valid;
        logic        we;
        logic        adel;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        dc;
        logic [31:0] cnt;
    } exp_t;

    exp_t model;
    exp_t sb[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] load_ref(input logic [2:0] ldt, input logic [1:0] a,
                                             input logic [31:0] rdata);
        int          ai;
        logic [31:0] sh;
        ai = int'(a);
        case (ldt)
            3'd1: begin sh = rdata >> (8 * (3 - ai)); return {{24{sh[7]}}, sh[7:0]}; end
            3'd2: begin sh = rdata >> (8 * (3 - ai)); return {24'h0, sh[7:0]}; end
            3'd3: begin sh = rdata >> (16 * (1 - ai / 2)); return {{16{sh[15]}}, sh[15:0]}; end
            3'd4: begin sh = rdata >> (16 * (1 - ai / 2)); return {16'h0, sh[15:0]}; end
            default: return rdata;
        endcase
    endfunction

    task automatic step(input string tag, input logic r, input logic v, input logic wreg,
                        input logic [4:0] wd, input logic [31:0] wdata, input logic ld,
                        input logic [2:0] ldt, input logic [31:0] rdata, input logic st,
                        input logic fl);
        exp_t e;
        logic mis;
        logic half;
        logic word;
        @(negedge clk);
        rst = r; mem_valid = v; mem_wreg = wreg; mem_wd = wd; mem_wdata = wdata;
        mem_ld = ld; mem_ldtype = ldt; mem_rdata = rdata; stall = st; flush = fl;

        half = (ldt == 3'd3) || (ldt == 3'd4);
        word = !(ldt inside {3'd1, 3'd2, 3'd3, 3'd4});
        mis  = v && ld && ((half && wdata[0]) || (word && wdata[1:0] != 2'b00));
        if (!r) begin
            model = '{valid: 1'b0, we: 1'b0, adel: 1'b0, waddr: 5'd0, wdata: 32'd0,
                      dc: 1'b0, cnt: 32'd0};
        end else if (fl) begin
            model.valid = 1'b0;
            model.we    = 1'b0;
            model.adel  = 1'b0;
            model.dc    = 1'b1;
        end else if (st) begin
            model.adel = 1'b0;
        end else begin
            model.valid = v;
            model.we    = v && wreg && (wd != 5'd0) && !mis;
            model.adel  = mis;
            model.waddr = wd;
            model.wdata = ld ? load_ref(ldt, wdata[1:0], rdata) : wdata;
            model.dc    = 1'b0;
            if (v && !mis) model.cnt = model.cnt + 32'd1;
        end
        sb.push_back(model);

        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_eq({tag, ".valid"}, {31'd0, wb_valid}, {31'd0, e.valid});
        check_eq({tag, ".we"},    {31'd0, wb_we},    {31'd0, e.we});
        check_eq({tag, ".adel"},  {31'd0, wb_adel},  {31'd0, e.adel});
        if (!e.dc) begin
            check_eq({tag, ".waddr"}, {27'd0, wb_waddr}, {27'd0, e.waddr});
            check_eq({tag, ".wdata"}, wb_wdata, e.wdata);
        end
`ifdef WB_RETIRE_CNT_EN
        check_eq({tag, ".cnt"}, retire_cnt, e.cnt);
`endif
    endtask

    initial begin
        rst = 1'b0; mem_valid = 1'b0; mem_wreg = 1'b0; mem_wd = 5'd0; mem_wdata = 32'd0;
        mem_ld = 1'b0; mem_ldtype = 3'd0; mem_rdata = 32'd0; stall = 1'b0; flush = 1'b0;
        model = '{valid: 1'b0, we: 1'b0, adel: 1'b0, waddr: 5'd0, wdata: 32'd0,
                  dc: 1'b0, cnt: 32'd0};

        // Reset dominates a live instruction plus stall/flush.
        step("rst0", 0, 1, 1, 5'd9, 32'hDEAD_BEEF, 0, 3'd0, 32'h0, 0, 0);
        step("rst1", 0, 1, 1, 5'd9, 32'hDEAD_BEEF, 1, 3'd0, 32'h0, 1, 1);

        step("alu",   1, 1, 1, 5'd5, 32'h1234_5678, 0, 3'd0, 32'h0, 0, 0);
        step("lb",    1, 1, 1, 5'd3, 32'h0000_1001, 1, 3'd1, 32'h1180_2233, 0, 0);
        step("lbu",   1, 1, 1, 5'd3, 32'h0000_1001, 1, 3'd2, 32'h1180_2233, 0, 0);
        step("lhu",   1, 1, 1, 5'd4, 32'h0000_1002, 1, 3'd4, 32'h1180_2233, 0, 0);
        step("lh0",   1, 1, 1, 5'd4, 32'h0000_1000, 1, 3'd3, 32'h8001_2233, 0, 0);
        step("lb3",   1, 1, 1, 5'd6, 32'h0000_1003, 1, 3'd1, 32'h1180_22F3, 0, 0);
        step("lw",    1, 1, 1, 5'd8, 32'h0000_1004, 1, 3'd0, 32'hCAFE_F00D, 0, 0);
        step("lwmis", 1, 1, 1, 5'd8, 32'h0000_1002, 1, 3'd0, 32'hCAFE_F00D, 0, 0);
        step("after", 1, 1, 1, 5'd8, 32'h0000_0040, 0, 3'd0, 32'h0, 0, 0);
        step("lhmis", 1, 1, 1, 5'd2, 32'h0000_1003, 1, 3'd3, 32'h1234_5678, 0, 0);
        step("rsv6",  1, 1, 1, 5'd2, 32'h0000_1000, 1, 3'd6, 32'h1234_5678, 0, 0);
        step("rsv5m", 1, 1, 1, 5'd2, 32'h0000_1001, 1, 3'd5, 32'h1234_5678, 0, 0);
        step("misst", 1, 1, 1, 5'd2, 32'h0000_1001, 1, 3'd0, 32'h1234_5678, 1, 0);

        step("cap7", 1, 1, 1, 5'd7, 32'hA5A5_0007, 0, 3'd0, 32'h0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step("stall", 1, 1, 1, 5'd1, 32'h0BAD_0BAD, 0, 3'd0, 32'h0, 1, 0);
        end
        step("stfl", 1, 1, 1, 5'd1, 32'h0BAD_0BAD, 0, 3'd0, 32'h0, 1, 1);
        step("r0",   1, 1, 1, 5'd0, 32'h0000_0099, 0, 3'd0, 32'h0, 0, 0);
        step("inv",  1, 0, 1, 5'd3, 32'h0000_0011, 0, 3'd0, 32'h0, 0, 0);

        step("cap9",   1, 1, 1, 5'd9, 32'h0000_0009, 0, 3'd0, 32'h0, 0, 0);
        step("stall9", 1, 1, 1, 5'd1, 32'h0000_0001, 0, 3'd0, 32'h0, 1, 0);
        step("rstst",  0, 1, 1, 5'd1, 32'h0000_0001, 0, 3'd0, 32'h0, 1, 0);

        for (int i = 0; i < 80; i++) begin
            step("rand", ($urandom_range(0, 19) != 0), 1'($urandom), 1'($urandom),
                 5'($urandom), $urandom, 1'($urandom), 3'($urandom), $urandom,
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0));
        end

`ifdef WB_RETIRE_CNT_EN
        @(negedge clk);
        dut.retire_q = 32'hFFFF_FFFF;
        model.cnt    = 32'hFFFF_FFFF;
        step("wrap", 1, 1, 1, 5'd0, 32'h0000_0010, 0, 3'd0, 32'h0, 0, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  synchronous, active-low reset.
REQ-002 SHALL have: mem_valid in 1 (MEM result present); mem_wreg in 1 (writes a GPR); mem_wd in 5 (dest reg); mem_wdata in 32 (ALU result / load address).
REQ-003 SHALL have: mem_ld in 1 (is load); mem_ldtype in 3 (000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU); mem_rdata in 32 (data-memory word, big-endian lanes).
REQ-004 SHALL have: stall in 1 (hold WB register); flush in 1 (insert bubble).
REQ-005 SHALL have: wb_we out 1, wb_waddr out 5, wb_wdata out 32 (regfile write port); wb_valid out 1; wb_adel out 1 (misaligned-load pulse).
REQ-006 SHALL have, when WB_RETIRE_CNT_EN is defined: retire_cnt out 32 (retired-instruction count).

Function
REQ-007 SHALL register all outputs; no combinational path from inputs to outputs; latency exactly 1 cycle.
REQ-008 SHALL, per clk edge with rst=1, use priority: flush, then stall, then capture.
REQ-009 SHALL, on flush, clear wb_valid, wb_we, wb_adel; wb_waddr/wb_wdata are don't-care.
REQ-010 SHALL, on stall without flush, hold every output unchanged, except wb_adel, which clears (1-cycle pulse).
REQ-011 SHALL, on capture, set wb_valid=mem_valid, wb_waddr=mem_wd.
REQ-012 SHALL set wb_we=mem_valid & mem_wreg & (mem_wd!=0) & ~misaligned.
REQ-013 SHALL, for non-load (mem_ld=0), set wb_wdata=mem_wdata.
REQ-014 SHALL, for loads, take byte lane by a=mem_wdata[1:0]: a=0 -> rdata[31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0].
REQ-015 SHALL, for LH/LHU, take half a[1]=0 -> rdata[31:16], a[1]=1 -> rdata[15:0].
REQ-016 SHALL sign-extend LB/LH, zero-extend LBU/LHU, pass LW unmodified.
REQ-017 SHALL treat reserved ldtype (101-111) as LW.
REQ-018 SHALL flag misaligned when mem_valid & mem_ld & ((LH/LHU & a[0]) | (LW & a!=0)); then wb_adel=1 for 1 cycle, wb_we=0, wb_valid=1.
REQ-019 SHALL drive wb_adel=0 on any capture without misalignment.

Reset
REQ-020 SHALL, on clk edge with rst=0, set wb_valid=0, wb_we=0, wb_waddr=0, wb_wdata=0, wb_adel=0, retire_cnt=0.
REQ-021 SHALL give rst=0 priority over flush and stall; a reset mid-stall discards the held instruction.

Configuration
REQ-022 SHALL, with WB_RETIRE_CNT_EN defined, increment retire_cnt by 1 per capture edge with mem_valid=1 and no misalignment, wrapping 0xFFFFFFFF -> 0; no increment on stall, flush or reset.
REQ-023 SHALL, with WB_RETIRE_CNT_EN undefined, omit the retire_cnt port and counter logic entirely, with all other behaviour identical.

Verification
REQ-024 SHALL cover: rst=0 one edge with mem_valid=1 -> all outputs 0 next cycle.
REQ-025 SHALL cover: non-load wd=5, wdata=0x12345678 -> next cycle wb_we=1, wb_waddr=5, wb_wdata=0x12345678.
REQ-026 SHALL cover: LB addr=0x...1, rdata=0x11802233 -> wb_wdata=0xFFFFFF80; LBU same -> 0x00000080; LHU addr=0x...2 -> 0x00002233.
REQ-027 SHALL cover: LW addr=0x...2 -> wb_adel=1 one cycle, wb_we=0; retire_cnt unchanged.
REQ-028 SHALL cover: stall=1 for 3 cycles after capture of wd=7 -> outputs held; stall=1 & flush=1 -> wb_valid=0, wb_we=0.
REQ-029 SHALL cover: mem_wd=0, mem_wreg=1 -> wb_we=0, wb_valid=1; with WB_RETIRE_CNT_EN, retire_cnt preset 0xFFFFFFFF plus one retire -> 0.
